// File: rtl/barrel_pkg.sv
// Shared definitions for the pipelined barrel shifter: mode encodings and
// the small decode helpers each shift stage uses.
package barrel_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;

  function automatic logic is_rotate(input logic [1:0] mode);
    return mode == MODE_ROT;
  endfunction

  // Reserved mode 2'b11 falls through to logical, so only an arithmetic right
  // shift ever fills with the sign bit.
  function automatic logic fill_bit(input logic [1:0] mode, input logic dir, input logic msb);
    return (mode == MODE_ARITH) && dir && msb;
  endfunction

endpackage

// File: rtl/barrel_stage.sv
// One pipeline stage: conditionally shifts the incoming word by 2^K, then
// registers the result together with the control that travels alongside it.
module barrel_stage
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH),
  parameter int K     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift,
  output logic             out_dir,
  output logic [1:0]       out_mode
);

  localparam int AMT = 1 << K;

  logic [2*WIDTH-1:0] doubled;
  logic [WIDTH-1:0]   fill;
  logic [WIDTH-1:0]   shifted;

  // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
  always_comb begin
    doubled = {in_data, in_data};
    fill    = {WIDTH{fill_bit(in_mode, in_dir, in_data[WIDTH-1])}};
    shifted = in_data;
    if (in_shift[K]) begin
      if (is_rotate(in_mode)) begin
        shifted = in_dir ? doubled[AMT +: WIDTH] : doubled[WIDTH-AMT +: WIDTH];
      end else if (in_dir) begin
        shifted = (in_data >> AMT) | (fill << (WIDTH - AMT));
      end else begin
        shifted = in_data << AMT;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all stages sample
  // their predecessors' pre-edge values and the pipe shifts by exactly one slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_shift <= '0;
      out_dir   <= 1'b0;
      out_mode  <= MODE_LOGIC;
    end else if (en) begin
      out_valid <= in_valid;
      out_data  <= shifted;
      out_shift <= in_shift;
      out_dir   <= in_dir;
      out_mode  <= in_mode;
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: SHW stages, one per shift-amount bit, advanced
// together by a single global enable that carries backpressure to the input.
module barrel_shifter_pipe
  import barrel_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             en;
  logic             valid_p [SHW+1];
  logic [WIDTH-1:0] data_p  [SHW+1];
  logic [SHW-1:0]   shift_p [SHW+1];
  logic             dir_p   [SHW+1];
  logic [1:0]       mode_p  [SHW+1];

  // The whole pipe moves only when the last slot is empty or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  assign valid_p[0] = in_valid;
  assign data_p[0]  = in_data;
  assign shift_p[0] = in_shift;
  assign dir_p[0]   = in_dir;
  assign mode_p[0]  = in_mode;

  for (genvar k = 0; k < SHW; k++) begin : g_stage
    barrel_stage #(
      .WIDTH (WIDTH),
      .SHW   (SHW),
      .K     (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (valid_p[k]),
      .in_data   (data_p[k]),
      .in_shift  (shift_p[k]),
      .in_dir    (dir_p[k]),
      .in_mode   (mode_p[k]),
      .out_valid (valid_p[k+1]),
      .out_data  (data_p[k+1]),
      .out_shift (shift_p[k+1]),
      .out_dir   (dir_p[k+1]),
      .out_mode  (mode_p[k+1])
    );
  end

  assign out_valid = valid_p[SHW];
  assign out_data  = data_p[SHW];

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Scoreboard bench for barrel_shifter_pipe (WIDTH = 8): a driver pushes expected
// results as operations are accepted, a monitor pops and compares on each output.
module tb_barrel_shifter_pipe;

  localparam int WIDTH = 8;
  localparam int SHW   = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_shift;
  logic             in_dir;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  barrel_shifter_pipe #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shift  (in_shift),
    .in_dir    (in_dir),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0] data;
    int          stamp;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  bit   bp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference written from the operation's definition on the whole word.
  function automatic logic [7:0] model(input logic [7:0] d, input int s,
                                       input logic dir, input logic [1:0] mode);
    logic [15:0] dd;
    dd = {d, d};
    case (mode)
      2'b01:   return dir ? 8'($signed(d) >>> s) : 8'(d << s);
      2'b10:   return dir ? 8'(dd >> s) : 8'(dd >> (8 - s));
      default: return dir ? 8'(d >> s) : 8'(d << s);
    endcase
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [7:0] d, input int s, input logic dir,
                       input logic [1:0] mode, input logic [7:0] req, input bit lat);
    exp_t x;
    in_valid = 1'b1;
    in_data  = d;
    in_shift = 3'(s);
    in_dir   = dir;
    in_mode  = mode;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (in_ready) begin
        x.data  = req;
        x.stamp = cyc + 1;
        x.lat   = lat;
        sb.push_back(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("issue_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 200 && sb.size() != 0; t++) @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: an output transfer happens on the coming edge when valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'(out_data), 32'hdead);
      end else begin
        e = sb.pop_front();
        check("out_data", 32'(out_data), 32'(e.data));
        if (e.lat) check("latency", 32'(cyc), 32'(e.stamp + 2));
      end
    end
  end

  typedef struct {
    logic [7:0] d;
    int         s;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] req;
  } vec_t;

  vec_t dirv[9] = '{
    '{8'h01, 7, 1'b0, 2'b00, 8'h80},
    '{8'h96, 4, 1'b1, 2'b00, 8'h09},
    '{8'h80, 3, 1'b1, 2'b01, 8'hF0},
    '{8'h70, 3, 1'b1, 2'b01, 8'h0E},
    '{8'h81, 1, 1'b0, 2'b01, 8'h02},
    '{8'h96, 4, 1'b1, 2'b10, 8'h69},
    '{8'h81, 7, 1'b0, 2'b10, 8'hC0},
    '{8'hA5, 0, 1'b1, 2'b10, 8'hA5},
    '{8'h96, 4, 1'b1, 2'b11, 8'h09}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int         s;
    logic       dir;
    logic [1:0] mode;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_shift  = '0;
    in_dir    = 1'b0;
    in_mode   = 2'b00;
    out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Directed vectors with hand-computed results, spaced out
    foreach (dirv[i]) begin
      issue(dirv[i].d, dirv[i].s, dirv[i].dir, dirv[i].mode, dirv[i].req, 1'b1);
      repeat (2) @(posedge clk);
      #1;
    end
    drain();

    // Back-to-back streaming, one result per cycle at fixed latency
    for (int i = 0; i < 16; i++) begin
      d    = 8'($urandom);
      s    = int'($urandom_range(0, 7));
      dir  = 1'($urandom);
      mode = 2'($urandom);
      issue(d, s, dir, mode, model(d, s, dir, mode), 1'b1);
    end
    drain();

    // Backpressure: fill the pipe, then stall for 5 cycles
    out_ready = 1'b0;
    issue(8'h3C, 2, 1'b0, 2'b00, 8'hF0, 1'b0);
    issue(8'hC3, 1, 1'b1, 2'b01, 8'hE1, 1'b0);
    issue(8'h12, 4, 1'b0, 2'b10, 8'h21, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    in_shift = 3'd1;
    in_dir   = 1'b1;
    in_mode  = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_data",  32'(out_data),  32'hF0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    issue(8'h55, 1, 1'b1, 2'b00, 8'h2A, 1'b0);
    drain();

    // Random out_ready toggling across 200 operations
    bp_on = 1'b1;
    fork
      while (bp_on) begin
        @(posedge clk);
        #1;
        if (bp_on) out_ready = 1'($urandom);
      end
    join_none
    for (int i = 0; i < 200; i++) begin
      d    = 8'($urandom);
      s    = int'($urandom_range(0, 7));
      dir  = 1'($urandom);
      mode = 2'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      issue(d, s, dir, mode, model(d, s, dir, mode), 1'b0);
    end
    bp_on = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight
    out_ready = 1'b0;
    issue(8'hAA, 1, 1'b0, 2'b00, 8'h54, 1'b0);
    issue(8'hBB, 2, 1'b1, 2'b00, 8'h2E, 1'b0);
    issue(8'hCC, 3, 1'b0, 2'b10, 8'h66, 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_out_data",  32'(out_data),  32'd0);
    check("async_rst_in_ready",  32'(in_ready),  32'd1);
    sb.delete();
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    issue(8'h0F, 4, 1'b0, 2'b10, 8'hF0, 1'b1);
    drain();
    repeat (4) @(negedge clk);
    check("no_stale_out_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
